ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting, 0xF3 set sample rate) to the mouse, using the open-drain ps2_clk/ps2_data lines shared with the mouse receiver. It sits in the mouse clock domain (mclk, 100 MHz) beside the receive path. The top level converts its *_oe outputs into tri-state drives, driving 1'b0 when oe=1 and 1'bz otherwise.

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_host_tx_if.sv | 25 ++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM state encoding, error codes, common mouse
// command bytes, counter width and a parity helper. Used by the host
// transmitter and the mouse receive path.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_SHIFT     = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_START_TO = 2'b01;
   localparam logic [1:0] ERR_BIT_TO   = 2'b10;
   localparam logic [1:0] ERR_NO_ACK   = 2'b11;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;

   // Timeout / inhibit counters saturate at this width.
   localparam int CNT_W = 21;

   // PS/2 frames carry odd parity: the parity bit makes the total 1-count odd.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command request / status bundle between a requester and ps2_host_tx.
//   tx_data/tx_valid : requester -> transmitter, byte taken on tx_valid & tx_ready
//   tx_ready         : transmitter idle
//   busy             : transaction in flight (receive path ignores the lines)
//   done / err       : one-cycle completion pulses
//   err_code         : reason for last err, holds until the next err
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   modport master (
      output tx_data, tx_valid,
      input  tx_ready, busy, done, err, err_code
   );

   modport slave (
      input  tx_data, tx_valid,
      output tx_ready, busy, done, err, err_code
   );
endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer plus falling-edge detector for one raw PS/2 line.
//   clk, rst  : local clock, async active-low reset
//   line_in   : asynchronous line level
//   level     : synchronized level
//   fall      : one-cycle pulse when the synchronized level goes 1 -> 0
// Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic prev_q, prev_d;

   always_comb begin
      meta_d = line_in;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign level = sync_q;
   assign fall  = prev_q & ~sync_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the mouse over
// the shared open-drain ps2_clk/ps2_data lines.
//   clk, rst                  : mouse-domain clock, async active-low reset
//   tx (ps2_host_tx_if.slave) : byte request, ready/busy, done/err pulses
//   ps2_clk_in, ps2_data_in   : raw line levels (asynchronous)
//   ps2_clk_oe, ps2_data_oe   : 1 = pull the line low; 0 = release
// All outputs come straight from flops, so an async reset releases both
// lines immediately and no pulse can be emitted during reset.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES       = 10000,
   parameter int START_TIMEOUT_CYCLES = 1500000,
   parameter int BIT_TIMEOUT_CYCLES   = 20000
) (
   input  logic          clk,
   input  logic          rst,
   ps2_host_tx_if.slave  tx,
   input  logic          ps2_clk_in,
   input  logic          ps2_data_in,
   output logic          ps2_clk_oe,
   output logic          ps2_data_oe
);
   localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] INH_PENULT = CNT_W'(INHIBIT_CYCLES - 2);
   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_TIMEOUT_CYCLES - 1);

   logic clk_lvl, clk_fall;
   logic data_lvl, data_fall_unused;

   ps2_line_sync u_clk_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_clk_in),
      .level   (clk_lvl),
      .fall    (clk_fall)
   );

   ps2_line_sync u_data_sync (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_data_in),
      .level   (data_lvl),
      .fall    (data_fall_unused)
   );

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   // {stop, parity, data[7:0]}, shifted right as each bit goes out.
   logic [9:0]       shift_q, shift_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;
   logic             tx_ready_q, tx_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;

   logic             fail;
   logic [1:0]       fail_code;
   logic             bit_to;

   always_comb begin
      state_d    = state_q;
      cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      idx_d      = idx_q;
      shift_d    = shift_q;
      clk_oe_d   = clk_oe_q;
      data_oe_d  = data_oe_q;
      tx_ready_d = tx_ready_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      fail       = 1'b0;
      fail_code  = ERR_NONE;
      bit_to     = (cnt_q >= BIT_LAST);

      case (state_q)
         ST_IDLE: begin
            clk_oe_d   = 1'b0;
            data_oe_d  = 1'b0;
            busy_d     = 1'b0;
            // Comes back high one cycle after a done/err pulse.
            tx_ready_d = 1'b1;
            if (tx.tx_valid && tx_ready_q) begin
               shift_d    = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
               state_d    = ST_INHIBIT;
               clk_oe_d   = 1'b1;
               tx_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end

         // Device edges here are the host's own pull-down or a device losing
         // arbitration; either way they are ignored.
         ST_INHIBIT: begin
            if (cnt_q >= INH_LAST) begin
               state_d   = ST_REQ;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b1;
            end else if (cnt_q == INH_PENULT) begin
               // Start bit goes down during the last inhibit cycle.
               data_oe_d = 1'b1;
            end
         end

         // The first device falling edge already asks for data bit 0.
         ST_REQ: begin
            if (clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = shift_q >> 1;
               idx_d     = 4'd0;
               state_d   = ST_SHIFT;
            end else if (cnt_q >= START_LAST) begin
               fail      = 1'b1;
               fail_code = ERR_START_TO;
            end
         end

         // idx_q is the index of the bit currently on the line.
         ST_SHIFT: begin
            if (clk_fall) begin
               data_oe_d = ~shift_q[0];
               shift_d   = shift_q >> 1;
               idx_d     = idx_q + 4'd1;
               cnt_d     = '0;
               if (idx_q == 4'd8) state_d = ST_ACK;
            end else if (bit_to) begin
               fail      = 1'b1;
               fail_code = ERR_BIT_TO;
            end
         end

         ST_ACK: begin
            if (clk_fall) begin
               if (!data_lvl) begin
                  state_d = ST_WAIT_IDLE;
               end else begin
                  fail      = 1'b1;
                  fail_code = ERR_NO_ACK;
               end
            end else if (bit_to) begin
               fail      = 1'b1;
               fail_code = ERR_BIT_TO;
            end
         end

         ST_WAIT_IDLE: begin
            if (clk_lvl && data_lvl) begin
               done_d     = 1'b1;
               state_d    = ST_IDLE;
               busy_d     = 1'b0;
               tx_ready_d = 1'b0;
            end else if (clk_fall) begin
               cnt_d = '0;
            end else if (bit_to) begin
               fail      = 1'b1;
               fail_code = ERR_BIT_TO;
            end
         end

         default: begin
            state_d   = ST_IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
         end
      endcase

      if (fail) begin
         state_d    = ST_IDLE;
         clk_oe_d   = 1'b0;
         data_oe_d  = 1'b0;
         busy_d     = 1'b0;
         tx_ready_d = 1'b0;
         err_d      = 1'b1;
         err_code_d = fail_code;
      end

      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
         tx_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
         tx_ready_q <= tx_ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign tx.tx_ready = tx_ready_q;
   assign tx.busy     = busy_q;
   assign tx.done     = done_q;
   assign tx.err      = err_q;
   assign tx.err_code = err_code_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   logic ps2_clk_oe, ps2_data_oe;
   logic ps2_clk_line, ps2_data_line;

   int checks = 0;
   int fails = 0;
   int n_done = 0;
   int n_err = 0;
   logic done_prev = 1'b0;
   logic rdy_after_done = 1'b0;

   ps2_host_tx_if bus ();

   // Wired-AND open-drain lines with pull-ups.
   assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES       (100),
      .START_TIMEOUT_CYCLES (2000),
      .BIT_TIMEOUT_CYCLES   (500)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx          (bus),
      .ps2_clk_in  (ps2_clk_line),
      .ps2_data_in (ps2_data_line),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.done) n_done <= n_done + 1;
      if (bus.err)  n_err  <= n_err + 1;
      if (done_prev) rdy_after_done <= bus.tx_ready;
      done_prev <= bus.done;
   end

   // Requests a byte, counts the inhibit time, then plays the device:
   // samples data on each rising clock (start bit on the host's release),
   // generates nf falling edges at a 40-cycle half period and optionally
   // pulls data low for the ack on the 11th edge. nf==0 returns right at
   // the first cycle of the host's request-to-send.
   task automatic send(input logic [7:0] d, input int nf, input bit ack,
                       output bit acc_ok, output logic [2:0] acc_obs,
                       output int inh, output logic [10:0] bits);
      int t;
      bits = '0;
      inh = 0;
      t = 0;
      while (!bus.tx_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      acc_ok = bus.tx_ready;
      bus.tx_data = d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      acc_obs = {bus.tx_ready, bus.busy, ps2_clk_oe};
      inh = ps2_clk_oe ? 1 : 0;
      t = 0;
      while (ps2_clk_oe && t < 1000) begin
         @(negedge clk);
         if (ps2_clk_oe) inh++;
         t++;
      end
      bits[0] = ps2_data_line;
      if (nf == 0) return;
      repeat (50) @(negedge clk);
      for (int k = 1; k <= nf; k++) begin
         dev_clk_low = 1'b1;
         repeat (40) @(negedge clk);
         dev_clk_low = 1'b0;
         if (k <= 10) bits[k] = ps2_data_line;
         if (k == 11) dev_data_low = 1'b0;
         if (k == 10 && ack) begin
            repeat (20) @(negedge clk);
            dev_data_low = 1'b1;
            repeat (20) @(negedge clk);
         end else begin
            repeat (40) @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_data = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL reset_tx_ready got=%b exp=1", bus.tx_ready); end
      checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin fails++; $display("FAIL reset_oe got=%b%b exp=00", ps2_clk_oe, ps2_data_oe); end
      checks++; if ({bus.done, bus.err} !== 2'b00) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", bus.done, bus.err); end
      checks++; if (bus.err_code !== 2'b00) begin fails++; $display("FAIL reset_err_code got=%b exp=00", bus.err_code); end
      rst = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   // Waits (bounded) for a done or err pulse count to move past the snapshot.
   task automatic wait_end(input int d0, input int e0);
      int t;
      t = 0;
      while (n_done == d0 && n_err == e0 && t < 1500) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_enable();
      bit ok; logic [2:0] obs; int inh; logic [10:0] bits; int d0, e0;
      d0 = n_done; e0 = n_err;
      send(8'hF4, 11, 1'b1, ok, obs, inh, bits);
      wait_end(d0, e0);
      checks++; if (ok !== 1'b1) begin fails++; $display("FAIL f4_ready_before got=%b exp=1", ok); end
      checks++; if (obs !== 3'b011) begin fails++; $display("FAIL f4_accept {rdy,busy,clk_oe} got=%b exp=011", obs); end
      checks++; if (inh !== 100) begin fails++; $display("FAIL f4_inhibit_len got=%0d exp=100", inh); end
      checks++; if (bits !== 11'b1_0_11110100_0) begin fails++; $display("FAIL f4_frame got=%b exp=%b", bits, 11'b1_0_11110100_0); end
      checks++; if (n_done - d0 !== 1) begin fails++; $display("FAIL f4_done_count got=%0d exp=1", n_done - d0); end
      checks++; if (n_err - e0 !== 0) begin fails++; $display("FAIL f4_err_count got=%0d exp=0", n_err - e0); end
      checks++; if (rdy_after_done !== 1'b1) begin fails++; $display("FAIL f4_ready_after_done got=%b exp=1", rdy_after_done); end
      checks++; if ({ps2_clk_oe, ps2_data_oe, bus.busy} !== 3'b000) begin fails++; $display("FAIL f4_idle_lines got=%b exp=000", {ps2_clk_oe, ps2_data_oe, bus.busy}); end
   endtask

   task automatic test_parity();
      bit ok; logic [2:0] obs; int inh; logic [10:0] bits; int d0, e0;
      d0 = n_done; e0 = n_err;
      send(8'h00, 11, 1'b1, ok, obs, inh, bits);
      wait_end(d0, e0);
      checks++; if (bits !== 11'b1_1_00000000_0) begin fails++; $display("FAIL par00_frame got=%b exp=%b", bits, 11'b1_1_00000000_0); end
      checks++; if (n_done - d0 !== 1) begin fails++; $display("FAIL par00_done got=%0d exp=1", n_done - d0); end
      d0 = n_done; e0 = n_err;
      send(8'hFF, 11, 1'b1, ok, obs, inh, bits);
      wait_end(d0, e0);
      checks++; if (bits !== 11'b1_1_11111111_0) begin fails++; $display("FAIL parff_frame got=%b exp=%b", bits, 11'b1_1_11111111_0); end
      checks++; if (n_done - d0 !== 1) begin fails++; $display("FAIL parff_done got=%0d exp=1", n_done - d0); end
   endtask

   task automatic test_start_timeout();
      bit ok; logic [2:0] obs; int inh; logic [10:0] bits; int d0, c;
      d0 = n_done;
      send(8'hF4, 0, 1'b0, ok, obs, inh, bits);
      c = 0;
      while (!bus.err && c < 3000) begin
         @(negedge clk);
         c++;
      end
      checks++; if (c !== 2000) begin fails++; $display("FAIL start_to_latency got=%0d exp=2000", c); end
      checks++; if (bus.err_code !== 2'b01) begin fails++; $display("FAIL start_to_code got=%b exp=01", bus.err_code); end
      checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin fails++; $display("FAIL start_to_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
      @(negedge clk);
      checks++; if ({bus.err, bus.tx_ready} !== 2'b01) begin fails++; $display("FAIL start_to_after {err,rdy} got=%b exp=01", {bus.err, bus.tx_ready}); end
      checks++; if (n_done !== d0) begin fails++; $display("FAIL start_to_no_done got=%0d exp=%0d", n_done, d0); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_bit_timeout();
      bit ok; logic [2:0] obs; int inh; logic [10:0] bits; int d0, e0;
      d0 = n_done; e0 = n_err;
      send(8'hF3, 5, 1'b1, ok, obs, inh, bits);
      wait_end(d0, e0);
      checks++; if (n_err - e0 !== 1) begin fails++; $display("FAIL bit_to_err_count got=%0d exp=1", n_err - e0); end
      checks++; if (bus.err_code !== 2'b10) begin fails++; $display("FAIL bit_to_code got=%b exp=10", bus.err_code); end
      checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin fails++; $display("FAIL bit_to_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
   endtask

   task automatic test_no_ack();
      bit ok; logic [2:0] obs; int inh; logic [10:0] bits; int d0, e0;
      d0 = n_done; e0 = n_err;
      send(8'hF4, 11, 1'b0, ok, obs, inh, bits);
      wait_end(d0, e0);
      checks++; if (n_err - e0 !== 1) begin fails++; $display("FAIL noack_err_count got=%0d exp=1", n_err - e0); end
      checks++; if (bus.err_code !== 2'b11) begin fails++; $display("FAIL noack_code got=%b exp=11", bus.err_code); end
      checks++; if (n_done !== d0) begin fails++; $display("FAIL noack_no_done got=%0d exp=%0d", n_done, d0); end
   endtask

   task automatic test_reset_mid();
      bit ok; logic [2:0] obs; int inh; logic [10:0] bits; int d0, e0;
      d0 = n_done; e0 = n_err;
      send(8'hA5, 3, 1'b1, ok, obs, inh, bits);
      checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before got=%b exp=1", bus.busy); end
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin fails++; $display("FAIL rst_mid_oe got=%b exp=00", {ps2_clk_oe, ps2_data_oe}); end
      checks++; if (bus.tx_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got=%b exp=1", bus.tx_ready); end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (n_done !== d0 || n_err !== e0) begin fails++; $display("FAIL rst_mid_no_pulse got=%0d/%0d exp=%0d/%0d", n_done, n_err, d0, e0); end
      d0 = n_done; e0 = n_err;
      send(8'hF3, 11, 1'b1, ok, obs, inh, bits);
      wait_end(d0, e0);
      checks++; if (bits !== 11'b1_1_11110011_0) begin fails++; $display("FAIL rst_f3_frame got=%b exp=%b", bits, 11'b1_1_11110011_0); end
      checks++; if (n_done - d0 !== 1 || n_err !== e0) begin fails++; $display("FAIL rst_f3_done got=%0d err=%0d exp=1/0", n_done - d0, n_err - e0); end
   endtask

   initial begin
      bus.tx_valid = 1'b0;
      bus.tx_data = 8'h00;
      test_reset();
      test_enable();
      test_parity();
      test_start_timeout();
      test_bit_timeout();
      test_no_ack();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
